keccak_share_arbiter: RTL and testbench

- Shares one SHA-3 hash core (padder + f_permutation + output stage) between two message requesters, on a whole-message basis.
- Grants the core to one requester at a time with round-robin priority.
- Issues a clean core reset before each message, forwards the owner's word stream, waits for the digest, captures it and signals completion to the owner.
- Sits between the user-side sources and the hash core top.

---
 rtl/keccak_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_keccak_share_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_share_arbiter.sv
// Round-robin arbiter that lends one SHA-3 core to two requesters a whole message at a time.
// Each message gets a one-cycle core clear, then the owner's words are streamed and the digest is captured.
module keccak_share_arbiter #(
  parameter int unsigned HASH_W = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  output logic [1:0]        grant,
  input  logic [31:0]       in0,
  input  logic [31:0]       in1,
  input  logic              in_ready0,
  input  logic              in_ready1,
  input  logic              is_last0,
  input  logic              is_last1,
  input  logic [1:0]        byte_num0,
  input  logic [1:0]        byte_num1,
  output logic              buffer_full0,
  output logic              buffer_full1,
  output logic [1:0]        done,
  output logic [HASH_W-1:0] hash_out,
  output logic              core_reset,
  output logic [31:0]       core_in,
  output logic              core_in_ready,
  output logic              core_is_last,
  output logic [1:0]        core_byte_num,
  input  logic              core_buffer_full,
  input  logic [HASH_W-1:0] core_out,
  input  logic              core_out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          done_q, done_d;
  logic [HASH_W-1:0]   hash_q, hash_d;
  logic                last_q, last_d;
  logic                owner;
  logic                pick;
  logic                accept;

  // grant is one-hot, so bit 1 alone identifies the owner
  assign owner = grant_q[1];

  // Word-path mux: only the owner reaches the core, and only while streaming
  always_comb begin
    core_in       = 32'd0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = 2'd0;
    buffer_full0  = 1'b1;
    buffer_full1  = 1'b1;
    if (state_q == S_STREAM) begin
      if (owner) begin
        core_in       = in1;
        core_in_ready = in_ready1;
        core_is_last  = is_last1;
        core_byte_num = byte_num1;
        buffer_full1  = core_buffer_full;
      end else begin
        core_in       = in0;
        core_in_ready = in_ready0;
        core_is_last  = is_last0;
        core_byte_num = byte_num0;
        buffer_full0  = core_buffer_full;
      end
    end
  end

  assign core_reset = reset | (state_q == S_CLEAR);
  assign accept     = core_in_ready & ~core_buffer_full;

  // Prefer the requester that was not served last; otherwise whichever is asking
  assign pick = req[~last_q] ? ~last_q : req[1];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = 2'b00;
    hash_d  = hash_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          grant_d = pick ? 2'b10 : 2'b01;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept && core_is_last) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Digest valid seen earlier belongs to the previous message and is ignored
        if (core_out_ready) begin
          hash_d  = core_out;
          done_d  = grant_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = owner;
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      hash_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      hash_q  <= hash_d;
      last_q  <= last_d;
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign hash_out = hash_q;

endmodule

// File: tb/tb_keccak_share_arbiter.sv
// Self-checking bench for keccak_share_arbiter; the bench also plays the hash core.
module tb_keccak_share_arbiter;

  localparam int unsigned HASH_W = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic [31:0]       in0, in1;
  logic              in_ready0, in_ready1;
  logic              is_last0, is_last1;
  logic [1:0]        byte_num0, byte_num1;
  logic              buffer_full0, buffer_full1;
  logic [1:0]        done;
  logic [HASH_W-1:0] hash_out;
  logic              core_reset;
  logic [31:0]       core_in;
  logic              core_in_ready;
  logic              core_is_last;
  logic [1:0]        core_byte_num;
  logic              core_buffer_full;
  logic [HASH_W-1:0] core_out;
  logic              core_out_ready;

  int tests = 0;
  int fails = 0;
  int last_m = 1;

  keccak_share_arbiter #(.HASH_W(HASH_W)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .in0(in0), .in1(in1), .in_ready0(in_ready0), .in_ready1(in_ready1),
    .is_last0(is_last0), .is_last1(is_last1),
    .byte_num0(byte_num0), .byte_num1(byte_num1),
    .buffer_full0(buffer_full0), .buffer_full1(buffer_full1),
    .done(done), .hash_out(hash_out), .core_reset(core_reset),
    .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num),
    .core_buffer_full(core_buffer_full), .core_out(core_out),
    .core_out_ready(core_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [HASH_W-1:0] obs, input logic [HASH_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_src(input int k, input logic rdy, input logic [31:0] w,
                         input logic lst, input logic [1:0] bn);
    if (k == 0) begin
      in_ready0 = rdy; in0 = w; is_last0 = lst; byte_num0 = bn;
    end else begin
      in_ready1 = rdy; in1 = w; is_last1 = lst; byte_num1 = bn;
    end
  endtask

  function automatic logic [1:0] onehot(input int k);
    return (k == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic bf_of(input int k);
    return (k == 1) ? buffer_full1 : buffer_full0;
  endfunction

  // One full message; entered at a negedge in IDLE with req already driven
  task automatic run_msg(input int nwords, input bit stall, input bit stale,
                         input bit drop, input bit fixed);
    int owner;
    int idx;
    int guard;
    int waits;
    logic [31:0] words[$];
    logic [HASH_W-1:0] dig;
    logic cbf;
    logic lastw;
    logic [1:0] bn;

    owner = req[1 - last_m] ? 1 - last_m : (req[0] ? 0 : 1);
    for (int i = 0; i < nwords; i++) words.push_back($urandom);
    if (stale) core_out_ready = 1'b1;

    step();
    check("clear_grant", grant, onehot(owner));
    check("clear_core_reset", core_reset, 1);
    check("clear_in_ready", core_in_ready, 0);
    check("clear_bf0", buffer_full0, 1);
    check("clear_bf1", buffer_full1, 1);
    check("clear_done", done, 0);
    if (!stale) core_out_ready = 1'b0;

    step();
    idx = 0;
    guard = 0;
    while (idx < nwords && guard < 200) begin
      cbf   = stall ? ((guard % 2) == 0) : ($urandom_range(0, 3) == 0);
      lastw = (idx == nwords - 1);
      bn    = lastw ? (fixed ? 2'd2 : 2'($urandom)) : 2'd0;
      set_src(owner, 1'b1, words[idx], lastw, bn);
      set_src(1 - owner, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 2'($urandom));
      core_buffer_full = cbf;
      #1;
      check("stream_in_ready", core_in_ready, 1);
      check("stream_word", core_in, words[idx]);
      check("stream_last", core_is_last, lastw);
      check("stream_byte_num", core_byte_num, bn);
      check("stream_bf_owner", bf_of(owner), cbf);
      check("stream_bf_other", bf_of(1 - owner), 1);
      check("stream_core_reset", core_reset, 0);
      check("stream_done", done, 0);
      if (drop && idx == 1) req[owner] = 1'b0;
      if (!cbf) idx++;
      guard++;
      step();
    end
    check("stream_completed", (idx == nwords), 1);

    set_src(owner, 1'b0, 32'd0, 1'b0, 2'd0);
    set_src(1 - owner, 1'b1, $urandom, 1'b1, 2'($urandom));
    core_buffer_full = 1'($urandom_range(0, 1));
    core_out_ready = 1'b0;
    #1;
    check("wait_in_ready", core_in_ready, 0);
    check("wait_is_last", core_is_last, 0);
    check("wait_bf_owner", bf_of(owner), 1);
    check("wait_bf_other", bf_of(1 - owner), 1);
    check("wait_grant", grant, onehot(owner));

    waits = $urandom_range(0, 3);
    for (int w = 0; w < waits; w++) begin
      step();
      check("wait_no_done", done, 0);
      check("wait_no_in_ready", core_in_ready, 0);
    end

    if (fixed) dig = {64{8'hA5}};
    else for (int j = 0; j < 16; j++) dig[j*32 +: 32] = $urandom;
    core_out = dig;
    core_out_ready = 1'b1;
    step();
    check("done_pulse", done, onehot(owner));
    check("done_hash", hash_out, dig);
    check("done_grant", grant, onehot(owner));
    step();
    check("idle_done_clear", done, 0);
    check("idle_grant", grant, 0);
    check("idle_hash_held", hash_out, dig);
    set_src(1 - owner, 1'b0, 32'd0, 1'b0, 2'd0);
    last_m = owner;
  endtask

  initial begin
    reset = 1'b1;
    req = 2'b00;
    in0 = '0; in1 = '0;
    in_ready0 = 1'b0; in_ready1 = 1'b0;
    is_last0 = 1'b0; is_last1 = 1'b0;
    byte_num0 = '0; byte_num1 = '0;
    core_buffer_full = 1'b0;
    core_out = '0;
    core_out_ready = 1'b0;

    step();
    step();
    check("rst_core_reset", core_reset, 1);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_hash", hash_out, 0);
    check("rst_bf0", buffer_full0, 1);
    check("rst_bf1", buffer_full1, 1);
    check("rst_in_ready", core_in_ready, 0);
    reset = 1'b0;
    #1;
    check("post_rst_core_reset", core_reset, 0);

    // Single requester, three words, known digest
    req = 2'b01;
    run_msg(3, 1'b0, 1'b0, 1'b0, 1'b1);
    req = 2'b00;
    step();
    check("idle_no_grant", grant, 0);

    // Both requesting for four one-word messages: strict alternation
    req = 2'b11;
    for (int m = 0; m < 4; m++) run_msg(1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall toggling 1,0,1,0 with stale digest valid and req dropped mid-message
    req = 2'b10;
    run_msg(4, 1'b1, 1'b1, 1'b1, 1'b0);
    req = 2'b01;
    run_msg(3, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of streaming a five-word message
    req = 2'b11;
    begin
      int owner;
      owner = req[1 - last_m] ? 1 - last_m : 0;
      step();
      check("rstmid_clear_grant", grant, onehot(owner));
      core_out_ready = 1'b0;
      step();
      core_buffer_full = 1'b0;
      for (int i = 0; i < 2; i++) begin
        set_src(owner, 1'b1, $urandom, 1'b0, 2'd0);
        step();
      end
      set_src(owner, 1'b1, $urandom, 1'b0, 2'd0);
      reset = 1'b1;
      #1;
      check("rstmid_core_reset", core_reset, 1);
      step();
      check("rstmid_grant", grant, 0);
      check("rstmid_done", done, 0);
      check("rstmid_hash", hash_out, 0);
      check("rstmid_in_ready", core_in_ready, 0);
      set_src(owner, 1'b0, 32'd0, 1'b0, 2'd0);
      req = 2'b01;
      reset = 1'b0;
      last_m = 1;
    end
    run_msg(2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized message mix
    for (int m = 0; m < 8; m++) begin
      req = 2'($urandom_range(1, 3));
      run_msg($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
